fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of YASAC; sits directly upstream of the code memory.
- Owns the fetch program counter and drives the code memory's 8-bit address. It latches the returned 16-bit word into the instruction register (IR) that feeds the decoder.
- Handles sequential fetch, stall, branch/call/return redirects and a small return-address stack (RAS).

Parameters:
- RAS_DEPTH, 4, number of return-address entries (1..16).
- RESET_VECTOR, 8'h00, fetch address after reset.
- HALT_OPCODE, 5'h1F, opcode IR[15:11] treated as halt (used only with FETCH_HALT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- STALL  in  1  hold the fetch stage this cycle.
- BRANCH  in  1  redirect to BRANCH_ADDR.
- CALL  in  1  push return address, redirect to BRANCH_ADDR.
- RET  in  1  pop return address, redirect to it.
- BRANCH_ADDR  in  8  target for BRANCH/CALL.
- MEM_ADDRESS  out  8  to code memory address (= fetch PC, combinational from register).
- MEM_DATA  in  16  from code memory data (asynchronous read).
- IR  out  16  instruction register.
- IR_VALID  out  1  IR holds a valid, non-squashed instruction.
- PC  out  8  address of the instruction in IR.
- RAS_EMPTY  out  1  RAS holds 0 entries.
- RAS_FULL  out  1  RAS holds RAS_DEPTH entries.
- RAS_ERR  out  1  sticky RAS overflow/underflow flag.
- HALTED  out  1  fetch frozen by halt opcode.

Behaviour:
- All state updates on the rising edge of CLK.
- RESET_N=0 at an edge sets: FPC=RESET_VECTOR, IR=16'h0000, PC=8'h00, IR_VALID=0, RAS count=0, RAS_ERR=0, HALTED=0.
  - Reset mid-operation discards everything, including RAS contents.
- MEM_ADDRESS = FPC at all times. There is no read handshake; the memory is combinational.
- Latency: the word at address A appears in IR one edge after FPC=A. The first valid IR (code[RESET_VECTOR]) appears at the first edge after reset deassertion.
- Redirect inputs are honoured only when IR_VALID=1. Otherwise they are ignored.
- Redirect priority when several are asserted: RET > CALL > BRANCH; lower-priority inputs are ignored.
- Honoured redirect (takes precedence over STALL):
  - IR_VALID<=0. The word fetched this cycle is wrong-path and is squashed (one bubble).
  - IR and PC hold.
  - BRANCH: FPC<=BRANCH_ADDR.
  - CALL with RAS not full: push PC+1 (mod 256), FPC<=BRANCH_ADDR.
  - CALL with RAS full: redirect still taken, push dropped, RAS_ERR<=1.
  - RET with RAS not empty: FPC<=top entry, pop.
  - RET with RAS empty: no redirect; treated as a normal sequential cycle; RAS_ERR<=1.
- No redirect, STALL=1: FPC, IR, PC, IR_VALID and RAS all hold.
- No redirect, STALL=0: IR<=MEM_DATA, PC<=FPC, IR_VALID<=1, FPC<=FPC+1. Wrap 8'hFF -> 8'h00, no flag.
- RAS is a LIFO of 8-bit entries; RAS_FULL and RAS_EMPTY are decoded from the registered count.
- RAS_ERR is cleared only by reset.
- Arithmetic: all address arithmetic is 8-bit modulo 256.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - When IR_VALID=1 and IR[15:11]==HALT_OPCODE, HALTED<=1 at the next edge.
  - While HALTED=1: FPC, IR, PC, IR_VALID and RAS hold; STALL and redirects are ignored.
  - Only reset clears HALTED.
- Undefined: HALTED is constant 0, the opcode is never inspected, and no halt logic is synthesised.

Test Plan:
- Reset then free-run, code[0..3]=16'h1101,16'h1202,16'h1303,16'h1404 -> IR sequence 1101,1202,1303,1404 on edges 1-4; PC 0,1,2,3; IR_VALID=1 from edge 1; MEM_ADDRESS 0,1,2,3,4.
- STALL=1 for 3 cycles with IR=16'h1202, PC=1 -> IR, PC and MEM_ADDRESS=2 frozen; resume gives IR=16'h1303.
- BRANCH with BRANCH_ADDR=8'h40 while PC=2 -> next edge IR_VALID=0, MEM_ADDRESS=8'h40; following edge IR=code[8'h40], PC=8'h40.
- CALL to 8'h80 at PC=8'h05, then RET at PC=8'h82 -> RAS pushes 8'h06; after RET and bubble, PC=8'h06; RAS_EMPTY returns to 1, RAS_ERR=0.
- RAS_DEPTH=4: five nested CALLs -> RAS_FULL=1 after fourth, RAS_ERR=1 after fifth. Then RET on empty -> sequential fetch continues, no bubble.
- FPC=8'hFF free-run -> PC=8'hFF, then PC=8'h00. With FETCH_HALT_EN and code[2]=16'hF800 -> HALTED=1 one edge after IR=16'hF800; BRANCH ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// YASAC instruction-fetch stage: fetch PC, instruction register, redirects and return-address stack.
// Optional halt-opcode freeze is compiled in with `define FETCH_HALT_EN.
module fetch_unit #(
  parameter int         RAS_DEPTH    = 4,
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [4:0] HALT_OPCODE  = 5'h1F
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        STALL,
  input  logic        BRANCH,
  input  logic        CALL,
  input  logic        RET,
  input  logic [7:0]  BRANCH_ADDR,
  output logic [7:0]  MEM_ADDRESS,
  input  logic [15:0] MEM_DATA,
  output logic [15:0] IR,
  output logic        IR_VALID,
  output logic [7:0]  PC,
  output logic        RAS_EMPTY,
  output logic        RAS_FULL,
  output logic        RAS_ERR,
  output logic        HALTED
);

  localparam int            CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);

  logic [7:0]    fpc_r, fpc_n_s;
  logic [15:0]   ir_r, ir_n_s;
  logic [7:0]    pc_r, pc_n_s;
  logic          ir_valid_r, ir_valid_n_s;
  logic [CW-1:0] ras_cnt_r, ras_cnt_n_s;
  logic          ras_err_r, ras_err_n_s;
  logic [7:0]    ras_mem_r [RAS_DEPTH];
  logic [7:0]    ras_top_s;
  logic [7:0]    push_val_s;
  logic          push_s;
  logic          ras_empty_s, ras_full_s;
  logic          halted_s;
  logic          do_ret_s, ret_err_s, do_call_s, do_branch_s;

  assign ras_empty_s = (ras_cnt_r == ZERO_CNT);
  assign ras_full_s  = (ras_cnt_r == FULL_CNT);
  assign push_val_s  = pc_r + 8'd1;

  // Redirects only act on a valid IR; RET outranks CALL, which outranks BRANCH.
  assign do_ret_s    = !halted_s && ir_valid_r && RET && !ras_empty_s;
  assign ret_err_s   = !halted_s && ir_valid_r && RET && ras_empty_s;
  assign do_call_s   = !halted_s && ir_valid_r && !RET && CALL;
  assign do_branch_s = !halted_s && ir_valid_r && !RET && !CALL && BRANCH;

  // Select the top-of-stack entry (AND-OR mux keyed on the live count).
  always_comb begin
    ras_top_s = 8'h00;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_top_s = ras_top_s | ({8{ras_cnt_r == CW'(i + 1)}} & ras_mem_r[i]);
    end
  end

  // Next-state decode for fetch PC, IR, PC, valid flag and RAS bookkeeping.
  always_comb begin
    fpc_n_s      = fpc_r;
    ir_n_s       = ir_r;
    pc_n_s       = pc_r;
    ir_valid_n_s = ir_valid_r;
    ras_cnt_n_s  = ras_cnt_r;
    ras_err_n_s  = ras_err_r;
    push_s       = 1'b0;
    if (halted_s) begin
      fpc_n_s = fpc_r;
    end else if (do_ret_s) begin
      ir_valid_n_s = 1'b0;
      fpc_n_s      = ras_top_s;
      ras_cnt_n_s  = ras_cnt_r - ONE_CNT;
    end else if (do_call_s) begin
      ir_valid_n_s = 1'b0;
      fpc_n_s      = BRANCH_ADDR;
      if (ras_full_s) begin
        ras_err_n_s = 1'b1;
      end else begin
        push_s      = 1'b1;
        ras_cnt_n_s = ras_cnt_r + ONE_CNT;
      end
    end else if (do_branch_s) begin
      ir_valid_n_s = 1'b0;
      fpc_n_s      = BRANCH_ADDR;
    end else if (STALL) begin
      fpc_n_s = fpc_r;
    end else begin
      ir_n_s       = MEM_DATA;
      pc_n_s       = fpc_r;
      ir_valid_n_s = 1'b1;
      fpc_n_s      = fpc_r + 8'd1;
    end
    // An underflowing RET falls through to the sequential/stall path above.
    if (ret_err_s) begin
      ras_err_n_s = 1'b1;
    end else begin
      ras_err_n_s = ras_err_n_s;
    end
  end

  // State registers, including the RAS storage array.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fpc_r      <= RESET_VECTOR;
      ir_r       <= 16'h0000;
      pc_r       <= 8'h00;
      ir_valid_r <= 1'b0;
      ras_cnt_r  <= ZERO_CNT;
      ras_err_r  <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= 8'h00;
      end
    end else begin
      fpc_r      <= fpc_n_s;
      ir_r       <= ir_n_s;
      pc_r       <= pc_n_s;
      ir_valid_r <= ir_valid_n_s;
      ras_cnt_r  <= ras_cnt_n_s;
      ras_err_r  <= ras_err_n_s;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (push_s && (ras_cnt_r == CW'(i))) begin
          ras_mem_r[i] <= push_val_s;
        end
      end
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_r;
  logic halt_set_s;

  assign halt_set_s = ir_valid_r && (ir_r[15:11] == HALT_OPCODE);

  // Sticky halt flag; only reset releases the frozen fetch stage.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      halted_r <= 1'b0;
    end else if (halt_set_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  assign halted_s = halted_r;
`else
  logic unused_halt_opcode_s;

  assign unused_halt_opcode_s = ^HALT_OPCODE;
  assign halted_s             = 1'b0;
`endif

  assign MEM_ADDRESS = fpc_r;
  assign IR          = ir_r;
  assign IR_VALID    = ir_valid_r;
  assign PC          = pc_r;
  assign RAS_EMPTY   = ras_empty_s;
  assign RAS_FULL    = ras_full_s;
  assign RAS_ERR     = ras_err_r;
  assign HALTED      = halted_s;

endmodule
